pwm_compare: RTL and testbench
==============================

// Module: pwm_compare
// PURPOSE
//  Sits downstream of the N-bit up counter and consumes its count value Q.
//  Turns the count into a PWM waveform using a double-buffered duty register.
//  Also produces period-wrap and compare-match event pulses.
//  Duty updates take effect only at a counter wrap, so the PWM never glitches mid-period.
// PARAMETERS
//  N             8   width of counter value and duty; must match the upstream counter
//  DEFAULT_DUTY  0   duty_active value after reset; must be < 2^N
// PORTS
//  clk          in   1  rising-edge clock, shared with the upstream counter
//  reset        in   1  synchronous, active-high reset
//  Q            in   N  count value from the upstream up counter
//  duty_in      in   N  new duty value offered for loading
//  duty_valid   in   1  duty_in is valid this cycle
//  duty_ready   out  1  shadow register can accept; high only in IDLE and reset low
//  pwm          out  1  registered PWM output
//  wrap         out  1  one-cycle pulse: counter wrapped (period boundary)
//  match        out  1  one-cycle pulse: count reached the effective duty
//  duty_active  out  N  duty currently applied
// BEHAVIOUR
//  - All state updates on the rising edge of clk; reset is sampled synchronously.
//  - Reset values:
//    - pwm = 0, wrap = 0, match = 0
//    - duty_active = DEFAULT_DUTY, prev_q = 0, shadow = 0
//    - state = IDLE
//    - duty_ready = 0 while reset is high
//  - prev_q is a register that follows Q every cycle.
//  - wrap_det is combinational: Q < prev_q, unsigned compare.
//    - Covers the normal 2^N-1 -> 0 rollover.
//    - Also covers an upstream counter reset (any drop in value).
//  - wrap is registered from wrap_det, so it appears 1 cycle after the wrapped Q is sampled.
//  - Shadow FSM, 2 states:
//    - IDLE: duty_ready = 1. On duty_valid & duty_ready: shadow <= duty_in, go to PENDING.
//    - PENDING: duty_ready = 0; duty_valid is ignored.
//    - PENDING on wrap_det: duty_active <= shadow, go to IDLE.
//  - Simultaneous duty_valid and wrap_det in IDLE: the value is captured into shadow and
//    the FSM goes to PENDING. It is applied at the NEXT wrap, never at this one.
//  - eff_duty = (PENDING & wrap_det) ? shadow : duty_active
//    - The new duty governs the same cycle in which it is applied.
//  - pwm <= (Q < eff_duty), unsigned; 1-cycle latency from Q.
//    - Duty 0: pwm is always 0.
//    - Duty 2^N-1: pwm is 0 only while Q = 2^N-1.
//  - match <= (Q == eff_duty) & (Q != prev_q).
//    - A stalled counter therefore produces a single pulse.
//    - Duty 0 matches when Q reaches 0 (the value-change rule still applies).
//  - Reset mid-operation: the pending shadow is discarded and duty_active returns to DEFAULT_DUTY.
//  - First sample after reset: prev_q = 0, so no spurious wrap is generated.
// TESTING (N=8, DEFAULT_DUTY=0, counter free-running unless stated)
//  1 Reset for 2 cycles with Q=37 -> pwm=0, wrap=0, match=0, duty_active=0, duty_ready=0;
//    after release -> duty_ready=1.
//  2 duty_in=64 with valid at Q=100 -> duty_ready=0 next cycle, duty_active stays 0 through Q=255;
//    edge after Q=0 -> wrap=1, duty_active=64, duty_ready=1.
//  3 Steady duty 64 -> pwm=1 for Q 0..63 and 0 for Q 64..255 (1-cycle lag);
//    match pulses exactly once per period, at Q=64.
//  4 Duty 0 -> pwm never 1. Duty 255 -> pwm=0 only for the sample at Q=255.
//  5 duty_valid=1 (duty_in=128) in the wrap cycle Q 255->0 while IDLE -> state=PENDING,
//    duty_active unchanged until the following wrap, then 128.
//  6 Hold Q=64 for 5 cycles with duty 64 -> a single match pulse.
//    Q jumps 200->5 -> wrap=1. Reset asserted in PENDING -> shadow dropped, duty_active=0.

Source files
------------

// File: rtl/pwm_compare.sv
// PWM comparator fed by an external up counter value Q.
// Double-buffered duty register, wrap and match event pulses.
//
// Ports:
//   clk         : rising-edge clock, shared with the upstream counter
//   reset       : synchronous, active-high reset
//   Q           : count value from the upstream up counter (N bits)
//   duty_in     : new duty value offered for loading (N bits)
//   duty_valid  : duty_in is valid this cycle
//   duty_ready  : shadow register can accept a new duty value
//   pwm         : registered PWM output, high while Q < effective duty
//   wrap        : one-cycle pulse, counter wrapped (period boundary)
//   match       : one-cycle pulse, count reached the effective duty
//   duty_active : duty value currently applied (N bits)
`timescale 1ns/1ps
module pwm_compare #(
    parameter int N            = 8,
    parameter int DEFAULT_DUTY = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] Q,
    input  logic [N-1:0] duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm,
    output logic         wrap,
    output logic         match,
    output logic [N-1:0] duty_active
);

    localparam logic [N-1:0] LP_DEF_DUTY = N'(DEFAULT_DUTY);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_prev_q;
    logic [N-1:0] r_shadow;
    logic [N-1:0] r_duty_active;
    logic         r_pwm;
    logic         r_wrap;
    logic         r_match;

    logic         w_wrap_det;
    logic         w_apply;
    logic [N-1:0] w_eff_duty;
    logic         w_q_changed;

    // Any drop in count is a period boundary: normal rollover
    // as well as an upstream counter reset.
    assign w_wrap_det  = (Q < r_prev_q);
    assign w_apply     = (r_state == PENDING) && w_wrap_det;

    // A duty being applied governs the compare in its own cycle.
    assign w_eff_duty  = w_apply ? r_shadow : r_duty_active;

    // Only a fresh count value may match, so a stalled
    // counter yields a single pulse.
    assign w_q_changed = (Q != r_prev_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_prev_q      <= '0;
            r_shadow      <= '0;
            r_duty_active <= LP_DEF_DUTY;
            r_pwm         <= 1'b0;
            r_wrap        <= 1'b0;
            r_match       <= 1'b0;
        end else begin
            r_prev_q <= Q;
            r_wrap   <= w_wrap_det;
            r_pwm    <= (Q < w_eff_duty);
            r_match  <= (Q == w_eff_duty) && w_q_changed;

            case (r_state)
                // A load coinciding with a wrap is held for the next wrap.
                IDLE: begin
                    if (duty_valid) begin
                        r_shadow <= duty_in;
                        r_state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_wrap_det) begin
                        r_duty_active <= r_shadow;
                        r_state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign duty_ready  = (r_state == IDLE) && !reset;
    assign pwm         = r_pwm;
    assign wrap        = r_wrap;
    assign match       = r_match;
    assign duty_active = r_duty_active;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed self-checking bench for pwm_compare (N=8, default duty 0).
// Drives Q as an external counter and checks every output.
`timescale 1ns/1ps
module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Q;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm;
    logic       wrap;
    logic       match;
    logic [7:0] duty_active;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    pwm_compare #(
        .N(8),
        .DEFAULT_DUTY(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Q(Q),
        .duty_in(duty_in),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .pwm(pwm),
        .wrap(wrap),
        .match(match),
        .duty_active(duty_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then sample 1 ns after the rising edge.
    task automatic step(input int q, input logic v, input int d);
        Q          = 8'(q);
        duty_valid = v;
        duty_in    = 8'(d);
        @(posedge clk);
        #1;
        duty_valid = 1'b0;
    endtask

    // Q = 1..255 with duty d active; optional load at Q=128.
    task automatic period(input int d, input int ld);
        for (int q = 1; q < 256; q++) begin
            if (q == 128 && ld >= 0) step(q, 1'b1, ld);
            else step(q, 1'b0, 0);
            chk($sformatf("pwm d=%0d q=%0d", d, q), pwm, (q < d));
            chk($sformatf("match d=%0d q=%0d", d, q), match, (q == d));
            chk($sformatf("wrap d=%0d q=%0d", d, q), wrap, 0);
        end
    endtask

    // Rollover 255 -> 0, applying expected duty d.
    task automatic wrap0(input int d);
        step(0, 1'b0, 0);
        chk($sformatf("wrap0 wrap d=%0d", d), wrap, 1);
        chk($sformatf("wrap0 duty d=%0d", d), duty_active, d);
        chk($sformatf("wrap0 ready d=%0d", d), duty_ready, 1);
        chk($sformatf("wrap0 pwm d=%0d", d), pwm, (0 < d));
        chk($sformatf("wrap0 match d=%0d", d), match, (d == 0));
    endtask

    initial begin
        reset      = 1'b1;
        Q          = 8'd37;
        duty_in    = 8'd0;
        duty_valid = 1'b0;

        // 1: reset with Q=37 for two cycles
        for (int i = 0; i < 2; i++) begin
            step(37, 1'b0, 0);
            chk("rst pwm", pwm, 0);
            chk("rst wrap", wrap, 0);
            chk("rst match", match, 0);
            chk("rst duty", duty_active, 0);
            chk("rst ready", duty_ready, 0);
        end
        reset = 1'b0;
        #1;
        chk("ready after rst", duty_ready, 1);

        // first sample after reset: prev_q=0, no wrap
        step(38, 1'b0, 0);
        chk("no spurious wrap", wrap, 0);
        chk("pwm duty0", pwm, 0);

        // 2: load 64 at Q=100, applied at next wrap
        for (int q = 39; q < 100; q++) step(q, 1'b0, 0);
        step(100, 1'b1, 64);
        chk("ready pending", duty_ready, 0);
        chk("duty held", duty_active, 0);
        for (int q = 101; q < 256; q++) step(q, 1'b0, 0);
        chk("duty held q255", duty_active, 0);
        chk("ready held q255", duty_ready, 0);
        wrap0(64);

        // 3: steady duty 64, then load 0
        period(64, 0);
        wrap0(0);

        // 4: duty 0 never high; then duty 255
        period(0, 255);
        wrap0(255);
        period(255, -1);

        // 5: load 128 in the wrap cycle while IDLE
        step(0, 1'b1, 128);
        chk("t5 wrap", wrap, 1);
        chk("t5 duty kept", duty_active, 255);
        chk("t5 ready", duty_ready, 0);
        chk("t5 pwm", pwm, 1);
        period(255, -1);
        chk("t5 still pending", duty_ready, 0);
        wrap0(128);
        period(128, 64);
        wrap0(64);

        // 6: stalled counter at 64 -> single match
        for (int q = 1; q < 64; q++) step(q, 1'b0, 0);
        chk("pre stall match", match, 0);
        step(64, 1'b0, 0);
        chk("stall match 1st", match, 1);
        chk("stall pwm", pwm, 0);
        for (int i = 0; i < 4; i++) begin
            step(64, 1'b0, 0);
            chk($sformatf("stall match %0d", i), match, 0);
        end
        for (int q = 65; q <= 200; q++) step(q, 1'b0, 0);
        chk("pre jump wrap", wrap, 0);
        step(5, 1'b0, 0);
        chk("jump wrap", wrap, 1);
        chk("jump pwm", pwm, 1);
        step(6, 1'b1, 100);
        chk("jump no wrap", wrap, 0);
        chk("load pending", duty_ready, 0);

        // reset in PENDING drops the shadow
        reset = 1'b1;
        step(7, 1'b0, 0);
        chk("rst2 duty", duty_active, 0);
        chk("rst2 ready", duty_ready, 0);
        chk("rst2 pwm", pwm, 0);
        reset = 1'b0;
        step(8, 1'b0, 0);
        chk("rst2 no wrap", wrap, 0);
        chk("rst2 ready", duty_ready, 1);
        step(0, 1'b0, 0);
        chk("rst2 wrap", wrap, 1);
        chk("rst2 shadow dropped", duty_active, 0);
        chk("rst2 match0", match, 1);
        chk("rst2 pwm0", pwm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
